jk_sync_counter: RTL and testbench
==================================

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
- REQ-001 Parameter WIDTH, default 4: counter width in bits.
- REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH, enforced by elaboration-time check.
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 rst_n  input  1  reset, synchronous and active-low.
- REQ-005 en  input  1  count enable.
- REQ-006 up  input  1  direction: 1 counts up, 0 counts down.
- REQ-007 load  input  1  synchronous parallel load request.
- REQ-008 d  input  WIDTH  parallel load value.
- REQ-009 q  output  WIDTH  registered count value.
- REQ-010 qn  output  WIDTH  bitwise complement of q at all times.
- REQ-011 tc  output  1  terminal count, combinational: en=1 and load=0 and ((up=1 and q=MODULUS-1) or (up=0 and q=0)).
- REQ-012 wrap  output  1  registered; 1 for exactly the cycle after a modulus wrap.
- REQ-013 load_err  output  1  registered; 1 for exactly the cycle after a load with d >= MODULUS.

Function
- REQ-014 Each q bit SHALL be held in one edge-triggered JK cell with encoding {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
- REQ-015 Priority per edge: rst_n=0, then load=1, then en=1, else hold.
- REQ-016 Load: bit i gets J=d[i], K=~d[i]; q=d on the next edge when d < MODULUS.
- REQ-017 Load with d >= MODULUS: q=MODULUS-1, load_err=1 on the next cycle.
- REQ-018 Count up: q=q+1 when q < MODULUS-1; q=0 when q=MODULUS-1, with wrap=1 on the next cycle.
- REQ-019 Count down: q=q-1 when q > 0; q=MODULUS-1 when q=0, with wrap=1 on the next cycle.
- REQ-020 Count J/K: derived per bit as toggle (11) or hold (00) from the binary-counter toggle chain; at a wrap, J/K SHALL force the wrap target value using set/reset codes.
- REQ-021 en=0 and load=0: every cell receives 00 and q holds; wrap=0 and load_err=0 on the next cycle.
- REQ-022 Direction change takes effect on the same edge as the new value of up; no extra latency.
- REQ-023 load=1 and en=1 together: load wins; no wrap is flagged.
- REQ-024 wrap and load_err SHALL never be 1 in the same cycle.
- REQ-025 Latency: load, count, and flag updates are all visible one edge after the request; tc has zero latency.
- REQ-026 tc combined with en forms the carry-enable for cascading; a higher digit with en=tc of the lower digit SHALL advance exactly once per lower-digit wrap.

Reset
- REQ-027 On a rising edge with rst_n=0: q=0, qn=all ones, wrap=0, load_err=0, regardless of en, load, d, and up.
- REQ-028 Reset mid-count SHALL discard any pending wrap or load_err flag.
- REQ-029 The first edge with rst_n=1 SHALL be treated as a normal cycle.
- REQ-030 Until the first reset edge, state is undefined; the bench SHALL NOT check outputs before it.

Structure
- REQ-031 Shared package jk_pkg SHALL hold the 2-bit JK command constants JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
- REQ-032 Sub-module jk_ff (clk, rst_n, j, k, q, qn): synchronous active-low reset to q=0.
- REQ-033 jk_sync_counter SHALL instantiate WIDTH jk_ff cells via generate.
- REQ-034 Next-state J/K computation, wrap/load_err registers, and tc logic SHALL reside in jk_sync_counter.

Verification
- REQ-035 Reset, then en=1, up=1 for 12 cycles (WIDTH=4, MODULUS=10): q=1..9,0,1,2; wrap=1 only in the cycle after q 9->0; tc=1 only while q=9.
- REQ-036 Load d=5, then en=1, up=0 for 7 cycles: q=5,4,3,2,1,0,9,8; wrap=1 in the cycle after q 0->9.
- REQ-037 Load d=12: q=9 and load_err=1 for one cycle, then load_err=0; qn=~q throughout.
- REQ-038 q=9 with load=1, d=3, en=1, up=1 on the same edge: q=3 and wrap=0.
- REQ-039 Count up to q=7, then rst_n=0 for one edge with en=1: q=0, flags 0; next edge counts to 1.
- REQ-040 Two instances cascaded (low.tc drives high.en), 25 enabled cycles from reset: {high,low}=2,5.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK command encoding used by the JK cells and by the counter's
// next-state logic, plus small helpers that build commands from a bit.
package jk_pkg;

    // {J,K} command codes for one edge-triggered JK cell
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Command that forces a cell to the given value regardless of its state
    function automatic logic [1:0] jk_force(input logic value);
        return value ? JK_SET : JK_RESET;
    endfunction

    // Command that toggles a cell when its counter-chain term is active
    function automatic logic [1:0] jk_toggle_if(input logic toggle);
        return toggle ? JK_TOGGLE : JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single edge-triggered JK flip-flop with synchronous active-low reset.
// {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);
    import jk_pkg::*;

    // JK state update; reset overrides any command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells.
// Counting uses the classic binary toggle chain; wraps and loads drive the
// cells with explicit set/reset commands so out-of-range values never appear.
// tc is combinational and doubles as the carry-enable for a cascaded digit.
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);
    import jk_pkg::*;

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("jk_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // Largest legal count and the modulus widened so 2**WIDTH still fits
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             at_max;
    logic             at_zero;
    logic             d_over;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [1:0]       cmd [WIDTH];

    assign at_max   = (q == MAX_VAL);
    assign at_zero  = (q == '0);
    assign d_over   = ({1'b0, d} >= MOD_EXT);
    assign load_val = d_over ? MAX_VAL : d;
    assign wrap_val = up ? '0 : MAX_VAL;

    // Terminal count: the next enabled edge will wrap in the current direction
    assign tc = en & ~load & (up ? at_max : at_zero);

    // Toggle chain: bit i toggles counting up when all lower bits are 1,
    // counting down when all lower bits are 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == 0) begin : g_lsb
                assign up_tog[gi] = 1'b1;
                assign dn_tog[gi] = 1'b1;
            end else begin : g_upper
                assign up_tog[gi] = &q[gi-1:0];
                assign dn_tog[gi] = ~|q[gi-1:0];
            end
        end
    endgenerate

    // Per-bit JK command: load forces the (clamped) load value, a wrap forces
    // the wrap target, otherwise the toggle chain steps the count.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = JK_HOLD;
            if (load) begin
                cmd[i] = jk_force(load_val[i]);
            end else if (en) begin
                if (tc) begin
                    cmd[i] = jk_force(wrap_val[i]);
                end else begin
                    cmd[i] = jk_toggle_if(up ? up_tog[i] : dn_tog[i]);
                end
            end
        end
    end

    // One JK cell per count bit
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_ff u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (cmd[gi][1]),
                .k     (cmd[gi][0]),
                .q     (q[gi]),
                .qn    (qn[gi])
            );
        end
    endgenerate

    // Event flags: wrap follows an enabled terminal count, load_err follows an
    // out-of-range load; tc excludes load so the two can never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= tc;
            load_err <= load & d_over;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter (WIDTH=4, MODULUS=10) plus a two-digit cascade.
module tb_jk_sync_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst_n, en, up, load;
    logic [W-1:0] d;
    logic [W-1:0] q, qn;
    logic         tc, wrap, load_err;

    logic         c_en, c_up, c_load;
    logic [W-1:0] c_d;
    logic [W-1:0] lo_q, lo_qn, hi_q, hi_qn;
    logic         lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: plain integer arithmetic modulo M
    int m_q;
    bit m_wrap, m_err;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .q(q), .qn(qn), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .load(c_load), .d(c_d),
        .q(lo_q), .qn(lo_qn), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err)
    );

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(c_up), .load(c_load), .d(c_d),
        .q(hi_q), .qn(hi_qn), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err)
    );

    function automatic bit model_tc();
        return en && !load && ((up && m_q == M - 1) || (!up && m_q == 0));
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            m_q = 0; m_wrap = 0; m_err = 0;
        end else if (load) begin
            m_wrap = 0;
            if (int'(d) >= M) begin m_q = M - 1; m_err = 1; end
            else begin m_q = int'(d); m_err = 0; end
        end else if (en) begin
            m_err = 0;
            if (up) begin m_wrap = (m_q == M - 1); m_q = (m_q + 1) % M; end
            else    begin m_wrap = (m_q == 0);     m_q = (m_q + M - 1) % M; end
        end else begin
            m_wrap = 0; m_err = 0;
        end
    endfunction

    // every edge goes through here so the reference never drifts
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd7;
        tick();
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL reset_q got %0d want 0", q); end
        n_cmp++; if (qn !== 4'hF) begin n_bad++; $display("FAIL reset_qn got %h want f", qn); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", load_err); end
        rst_n = 1'b1; en = 1'b0; load = 1'b0; d = '0;
    endtask

    task automatic test_count_up();
        int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int prev = 0;
        en = 1'b1; up = 1'b1; load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (tc !== (prev == 9)) begin n_bad++; $display("FAIL up_tc cyc %0d got %b want %b", c, tc, prev == 9); end
            tick();
            n_cmp++; if (q !== W'(exp_q[c])) begin n_bad++; $display("FAIL up_q cyc %0d got %0d want %0d", c, q, exp_q[c]); end
            n_cmp++; if (qn !== ~W'(exp_q[c])) begin n_bad++; $display("FAIL up_qn cyc %0d got %h want %h", c, qn, ~W'(exp_q[c])); end
            n_cmp++; if (wrap !== (prev == 9)) begin n_bad++; $display("FAIL up_wrap cyc %0d got %b want %b", c, wrap, prev == 9); end
            prev = exp_q[c];
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        int exp_q [7] = '{4, 3, 2, 1, 0, 9, 8};
        int prev = 5;
        load = 1'b1; d = 4'd5; en = 1'b0;
        tick();
        n_cmp++; if (q !== 4'd5) begin n_bad++; $display("FAIL dn_load_q got %0d want 5", q); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL dn_load_err got %b want 0", load_err); end
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int c = 0; c < 7; c++) begin
            n_cmp++; if (tc !== (prev == 0)) begin n_bad++; $display("FAIL dn_tc cyc %0d got %b want %b", c, tc, prev == 0); end
            tick();
            n_cmp++; if (q !== W'(exp_q[c])) begin n_bad++; $display("FAIL dn_q cyc %0d got %0d want %0d", c, q, exp_q[c]); end
            n_cmp++; if (wrap !== (prev == 0)) begin n_bad++; $display("FAIL dn_wrap cyc %0d got %b want %b", c, wrap, prev == 0); end
            prev = exp_q[c];
        end
        en = 1'b0;
    endtask

    task automatic test_load_err();
        int dv [5]    = '{12, 10, 9, 15, 0};
        int exp_q [5] = '{9, 9, 9, 9, 0};
        bit exp_e [5] = '{1, 1, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            load = 1'b1; en = 1'b0; d = W'(dv[i]);
            tick();
            n_cmp++; if (q !== W'(exp_q[i])) begin n_bad++; $display("FAIL lerr_q d=%0d got %0d want %0d", dv[i], q, exp_q[i]); end
            n_cmp++; if (qn !== ~W'(exp_q[i])) begin n_bad++; $display("FAIL lerr_qn d=%0d got %h want %h", dv[i], qn, ~W'(exp_q[i])); end
            n_cmp++; if (load_err !== exp_e[i]) begin n_bad++; $display("FAIL lerr_flag d=%0d got %b want %b", dv[i], load_err, exp_e[i]); end
            n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL lerr_wrap d=%0d got %b want 0", dv[i], wrap); end
            load = 1'b0;
            tick();
            n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL lerr_clear d=%0d got %b want 0", dv[i], load_err); end
            n_cmp++; if (q !== W'(exp_q[i])) begin n_bad++; $display("FAIL lerr_hold d=%0d got %0d want %0d", dv[i], q, exp_q[i]); end
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; d = 4'd9; en = 1'b0;
        tick();
        load = 1'b1; d = 4'd3; en = 1'b1; up = 1'b1;
        n_cmp++; if (tc !== 1'b0) begin n_bad++; $display("FAIL prio_tc got %b want 0", tc); end
        tick();
        n_cmp++; if (q !== 4'd3) begin n_bad++; $display("FAIL prio_q got %0d want 3", q); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL prio_wrap got %b want 0", wrap); end
        n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL prio_err got %b want 0", load_err); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_midcount();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        en = 1'b1; up = 1'b1; load = 1'b0;
        repeat (7) tick();
        n_cmp++; if (q !== 4'd7) begin n_bad++; $display("FAIL mid_q7 got %0d want 7", q); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL mid_rst_q got %0d want 0", q); end
        n_cmp++; if (wrap !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags got %b%b want 00", wrap, load_err); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (q !== 4'd1) begin n_bad++; $display("FAIL mid_resume got %0d want 1", q); end
        // reset on the edge that would have wrapped / flagged a bad load
        load = 1'b1; d = 4'd9; tick(); load = 1'b0;
        rst_n = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_cmp++; if (wrap !== 1'b0 || q !== 4'd0) begin n_bad++; $display("FAIL mid_drop_wrap got q=%0d wrap=%b want q=0 wrap=0", q, wrap); end
        load = 1'b1; d = 4'd13;
        tick();
        n_cmp++; if (load_err !== 1'b0 || q !== 4'd0) begin n_bad++; $display("FAIL mid_drop_err got q=%0d err=%b want q=0 err=0", q, load_err); end
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up    = ($urandom_range(0, 9) < 6);
            d     = W'($urandom_range(0, 15));
            #1;
            n_cmp++; if (tc !== model_tc()) begin n_bad++; $display("FAIL rnd_tc cyc %0d got %b want %b", c, tc, model_tc()); end
            tick();
            n_cmp++; if (q !== W'(m_q)) begin n_bad++; $display("FAIL rnd_q cyc %0d got %0d want %0d", c, q, m_q); end
            n_cmp++; if (qn !== ~q) begin n_bad++; $display("FAIL rnd_qn cyc %0d got %h want %h", c, qn, ~q); end
            n_cmp++; if (wrap !== m_wrap) begin n_bad++; $display("FAIL rnd_wrap cyc %0d got %b want %b", c, wrap, m_wrap); end
            n_cmp++; if (load_err !== m_err) begin n_bad++; $display("FAIL rnd_err cyc %0d got %b want %b", c, load_err, m_err); end
            n_cmp++; if (wrap === 1'b1 && load_err === 1'b1) begin n_bad++; $display("FAIL rnd_excl cyc %0d got wrap=1 err=1 want not both", c); end
        end
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_cascade();
        rst_n = 1'b0; c_en = 1'b0;
        tick();
        rst_n = 1'b1; c_en = 1'b1;
        repeat (25) tick();
        c_en = 1'b0;
        #1;
        n_cmp++; if (lo_q !== 4'd5) begin n_bad++; $display("FAIL casc_lo got %0d want 5", lo_q); end
        n_cmp++; if (hi_q !== 4'd2) begin n_bad++; $display("FAIL casc_hi got %0d want 2", hi_q); end
        n_cmp++; if (lo_qn !== ~4'd5 || hi_qn !== ~4'd2) begin n_bad++; $display("FAIL casc_qn got %h %h want a d", lo_qn, hi_qn); end
        n_cmp++; if ({lo_wrap, hi_wrap, lo_err, hi_err, lo_tc, hi_tc} !== 6'b0) begin
            n_bad++; $display("FAIL casc_flags got %b want 000000", {lo_wrap, hi_wrap, lo_err, hi_err, lo_tc, hi_tc});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_d = '0;
        m_q = 0; m_wrap = 0; m_err = 0;
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_err();
        test_load_priority();
        test_reset_midcount();
        test_random();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
